// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve in a single cycle.
module iter_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       div_ctrl,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic            is_rem;
  logic            neg_q;
  logic            neg_r;

  // Operand decode for the request presented on the inputs
  logic             is_signed_c;
  logic             a_neg_c;
  logic             b_neg_c;
  logic             div_zero_c;
  logic             ovf_c;
  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic [WIDTH-1:0] fast_res_c;

  always_comb begin
    is_signed_c = ~div_ctrl[0];
    a_neg_c     = is_signed_c & dividend[WIDTH-1];
    b_neg_c     = is_signed_c & divisor[WIDTH-1];
    a_mag_c     = a_neg_c ? (~dividend + WIDTH'(1)) : dividend;
    b_mag_c     = b_neg_c ? (~divisor + WIDTH'(1)) : divisor;
    div_zero_c  = (divisor == '0);
    ovf_c       = is_signed_c && (dividend == MIN_NEG) && (divisor == '1);
    fast_res_c  = '0;
    if (div_zero_c) begin
      fast_res_c = div_ctrl[1] ? dividend : '1;
    end else if (ovf_c) begin
      fast_res_c = div_ctrl[1] ? '0 : dividend;
    end
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits
  logic [WIDTH:0]   rem_sh_c;
  logic [WIDTH:0]   diff_c;
  logic [WIDTH-1:0] q_next_c;
  logic [WIDTH-1:0] r_next_c;
  logic [WIDTH-1:0] final_res_c;

  always_comb begin
    rem_sh_c    = {rem, quo[WIDTH-1]};
    diff_c      = rem_sh_c - {1'b0, dvs};
    q_next_c    = {quo[WIDTH-2:0], ~diff_c[WIDTH]};
    r_next_c    = diff_c[WIDTH] ? rem_sh_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
    final_res_c = q_next_c;
    if (is_rem) begin
      final_res_c = neg_r ? (~r_next_c + WIDTH'(1)) : r_next_c;
    end else if (neg_q) begin
      final_res_c = ~q_next_c + WIDTH'(1);
    end
  end

  // Control FSM with registered busy/done/result; rst beats flush beats start
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      count  <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            is_rem <= div_ctrl[1];
            neg_q  <= a_neg_c ^ b_neg_c;
            neg_r  <= a_neg_c;
            dvs    <= b_mag_c;
            quo    <= a_mag_c;
            rem    <= '0;
            count  <= '0;
            busy   <= 1'b1;
            if (div_zero_c || ovf_c) begin
              result <= fast_res_c;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          quo   <= q_next_c;
          rem   <= r_next_c;
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            result <= final_res_c;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          count <= '0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          count <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (legal values 8..64, even).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a new operation; accepted only when busy=0.
REQ-005 SHALL have port flush, input, 1 bit: abort any operation in progress (pipeline flush/redirect).
REQ-006 SHALL have port div_ctrl, input, 2 bits: 00 DIV, 01 DIVU, 10 REM, 11 REMU, equal to funct3[1:0] of the RV32M opcode.
REQ-007 SHALL have port dividend, input, WIDTH bits: numerator, sampled with start.
REQ-008 SHALL have port divisor, input, WIDTH bits: denominator, sampled with start.
REQ-009 SHALL have port busy, output, 1 bit: high whenever state != IDLE; this is the pipeline-stall source.
REQ-010 SHALL have port done, output, 1 bit: single-cycle pulse marking result valid.
REQ-011 SHALL have port result, output, WIDTH bits: quotient or remainder; registered and held until the next accepted start.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN and DONE; done=1 only in DONE; busy=1 in RUN and DONE.
REQ-013 IDLE: on an edge with start=1, flush=0 and rst=0, SHALL latch dividend, divisor and div_ctrl, then go to RUN with iteration count 0, or take the fast path of REQ-017/018.
REQ-014 RUN: SHALL resolve one quotient bit per edge using radix-2 restoring division on unsigned magnitudes, and SHALL enter DONE after exactly WIDTH RUN edges.
REQ-015 Latency: with start sampled on edge k, done SHALL be high in the cycle after edge k+WIDTH (WIDTH+1 edges in total) and SHALL return to 0 and busy to 0 after edge k+WIDTH+1.
REQ-016 Signed ops (DIV, REM): operands SHALL be converted to magnitudes; quotient negated when the operand signs differ; remainder takes the sign of the dividend; unsigned ops use raw operands.
REQ-017 Divisor = 0 fast path: SHALL go IDLE->DONE in one edge (done visible after 1 edge) with quotient = all ones and remainder = dividend, for signed and unsigned ops.
REQ-018 Signed overflow fast path (DIV/REM, dividend = 1 followed by WIDTH-1 zeros, divisor = all ones): SHALL go IDLE->DONE in one edge with quotient = dividend and remainder = 0.
REQ-019 result SHALL be loaded on the edge entering DONE and SHALL hold its value in IDLE.
REQ-020 start while busy=1 SHALL be ignored, and operands SHALL not change.
REQ-021 flush=1 on any edge SHALL force IDLE on that edge; done SHALL not pulse for the aborted op; result SHALL keep its previous value.
REQ-022 flush and start on the same edge: flush SHALL win and the start SHALL not be accepted.
REQ-023 Flush in DONE: done SHALL drop on that edge; result has already been updated.
REQ-024 A start in the cycle immediately after DONE (state IDLE) SHALL be accepted, so back-to-back ops are separated by exactly one IDLE cycle.

Reset
REQ-025 rst=1 on an edge SHALL force IDLE, busy=0, done=0, result=0 and the iteration count to 0, overriding start and flush.
REQ-026 rst asserted mid-RUN SHALL abort the operation with no done pulse; a start on the first edge after rst deasserts SHALL be accepted.

Verification (WIDTH=32)
REQ-027 DIVU 100/7 with start on edge k -> done high after edge k+32, result 14; REMU same operands -> 2; busy low after edge k+33.
REQ-028 DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIV 7/-2 -> -3; REM 7/-2 -> 1.
REQ-029 DIVU 0x1234/0 -> done after 1 edge, result 0xFFFFFFFF; REMU 0x1234/0 -> result 0x1234.
REQ-030 DIV 0x80000000/0xFFFFFFFF -> done after 1 edge, result 0x80000000; REM same operands -> result 0.
REQ-031 Start DIVU 50/5, flush at RUN iteration 10 -> busy=0 next cycle, no done pulse, result unchanged; new start 9/3 -> result 3 after 33 edges; start asserted during busy is ignored.
REQ-032 rst at RUN iteration 5 -> busy=0, done=0, result=0 after that edge; a following DIVU 10/3 -> result 3.
